// File: rtl/adder_recover_pkg.sv
// Shared definitions for the bit-serial operand recovery block.
//   state_e        : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand width; the sum is one bit wider
//   idx_w()        : width of the bit index counter for a given operand width
package adder_recover_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 6;

  // The index runs 0..WIDTH and then steps once more to WIDTH+1 on the final
  // bit, so it must hold WIDTH+1 without wrapping.
  function automatic int idx_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/adder_operand_recover_fs_bit.sv
// One-bit full subtractor: d = s - a - bw_in, with borrow out.
//   s      : minuend bit
//   a      : subtrahend bit
//   bw_in  : incoming borrow
//   d      : difference bit
//   bw_out : outgoing borrow
module fs_bit (
  input  logic s,
  input  logic a,
  input  logic bw_in,
  output logic d,
  output logic bw_out
);

  assign d      = s ^ a ^ bw_in;
  // Borrow when a exceeds s outright, or when they are equal and a borrow is
  // already pending.
  assign bw_out = (~s & a) | (~(s ^ a) & bw_in);

endmodule

// File: rtl/adder_operand_recover.sv
// Bit-serial operand recovery: given a WIDTH+1-bit sum S and a WIDTH-bit
// operand A, computes B = (S - A) mod 2^WIDTH one bit per clock, LSB first,
// and flags sums that no WIDTH-bit B can produce.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake; in_sum, in_a sampled on accept
//   out_valid / out_ready : result handshake; out_b, out_err held in DONE
//   out_err               : 1 when S < A or S - A > 2^WIDTH - 1
module adder_operand_recover
  import adder_recover_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err
);

  localparam int            IW       = idx_w(WIDTH);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH:0]   s_q, s_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   diff_q, diff_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             bw_q, bw_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             err_q, err_d;
  logic             in_ready_q, out_valid_q;

  logic             fs_d_s;
  logic             fs_bw_s;

  // Single subtractor cell, reused for every bit position in turn.
  fs_bit u_fs_bit (
    .s      (s_q[idx_q]),
    .a      (a_q[idx_q]),
    .bw_in  (bw_q),
    .d      (fs_d_s),
    .bw_out (fs_bw_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    a_d     = a_q;
    diff_d  = diff_q;
    idx_d   = idx_q;
    bw_d    = bw_q;
    b_d     = b_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_sum;
          a_d     = {1'b0, in_a};
          diff_d  = {(WIDTH + 1){1'b0}};
          idx_d   = IDX_ZERO;
          bw_d    = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // Difference bits enter at the MSB end so that after WIDTH+1 shifts
        // bit 0 has reached the LSB.
        diff_d = {fs_d_s, diff_q[WIDTH:1]};
        bw_d   = fs_bw_s;
        idx_d  = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          b_d     = diff_d[WIDTH-1:0];
          // A final borrow means S < A; a set top bit means S - A needs more
          // than WIDTH bits. Either way no WIDTH-bit B exists.
          err_d   = fs_bw_s | fs_d_s;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= {(WIDTH + 1){1'b0}};
      a_q         <= {(WIDTH + 1){1'b0}};
      diff_q      <= {(WIDTH + 1){1'b0}};
      idx_q       <= IDX_ZERO;
      bw_q        <= 1'b0;
      b_q         <= {WIDTH{1'b0}};
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      a_q         <= a_d;
      diff_q      <= diff_d;
      idx_q       <= idx_d;
      bw_q        <= bw_d;
      b_q         <= b_d;
      err_q       <= err_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_b     = b_q;
  assign out_err   = err_q;

endmodule
